// File: rtl/d02_truth_scan_pkg.sv
// Shared types and constants for the truth-table scanner.
package d02_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int N_IN    = 4;
  localparam int TABLE_W = 16;

  // Golden table for the lab01 expression NOR(A,B) & NAND(C,D).
  localparam logic [15:0] LAB01_EXPECTED = 16'h0007;

endpackage

// File: rtl/d02_truth_scan_if.sv
// Control and result bundle between a scan requester and the truth scanner.
interface d02_truth_scan_if;
  import d02_pkg::*;

  logic               start;
  logic               busy;
  logic               done;
  logic               pass;
  logic [TABLE_W-1:0] truth_table;
  logic [4:0]         err_cnt;
  logic [3:0]         first_err;

  modport master (
    output start,
    input  busy, done, pass, truth_table, err_cnt, first_err
  );

  modport slave (
    input  start,
    output busy, done, pass, truth_table, err_cnt, first_err
  );

endinterface

// File: rtl/d02_hold_timer.sv
// Counts 0..HOLD-1 while enabled; last marks the final cycle of a hold window.
module d02_hold_timer #(
  parameter int HOLD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(HOLD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

  assign last = (cnt == MAX_CNT);

endmodule

// File: rtl/d02_truth_scan.sv
// Sweeps all 16 input combinations through a 4-input block and checks its
// captured truth table against EXPECTED.
module d02_truth_scan
  import d02_pkg::*;
#(
  parameter int               HOLD     = 2,
  parameter logic [TABLE_W-1:0] EXPECTED = LAB01_EXPECTED
) (
  input  logic clk,
  input  logic rst,
  input  logic Y,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  d02_truth_scan_if.slave bus
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SCAN   = SCAN;
  localparam logic [1:0] S_FINISH = FINISH;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TABLE_W - 1);

  logic [1:0]      state;
  logic [N_IN-1:0] idx;
  logic [N_IN-1:0] stim;
  logic            hold_last;
  logic            mismatch;
  logic [4:0]      err_next;

  d02_hold_timer #(.HOLD(HOLD)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != S_SCAN),
    .en   (state == S_SCAN),
    .last (hold_last)
  );

  assign mismatch = Y ^ EXPECTED[idx];
  assign err_next = bus.err_cnt + {4'd0, mismatch};
  assign {A, B, C, D} = stim;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      idx             <= '0;
      stim            <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.pass        <= 1'b0;
      bus.truth_table <= '0;
      bus.err_cnt     <= '0;
      bus.first_err   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state           <= S_SCAN;
            idx             <= '0;
            stim            <= '0;
            bus.busy        <= 1'b1;
            bus.pass        <= 1'b0;
            bus.truth_table <= '0;
            bus.err_cnt     <= '0;
            bus.first_err   <= '0;
          end
        end
        S_SCAN: begin
          if (hold_last) begin
            bus.truth_table[idx] <= Y;
            bus.err_cnt          <= err_next;
            if (mismatch && bus.err_cnt == 5'd0) begin
              bus.first_err <= idx;
            end
            // The next vector is registered here so it appears exactly
            // when its hold window starts.
            if (idx == LAST_IDX) begin
              state    <= S_FINISH;
              stim     <= '0;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= (err_next == 5'd0);
            end else begin
              idx  <= idx + N_IN'(1);
              stim <= idx + N_IN'(1);
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/d02_truth_scan.md
Name: d02_truth_scan

Overview:
- Sequential stimulus/capture stage that wraps a 4-input, 1-output combinational block (e.g. the D01 logic-expression modules).
- On a start pulse it drives all 16 input combinations onto A,B,C,D (A = MSB), holds each for HOLD cycles, and samples the block's Y on the last hold cycle.
- Builds a 16-bit truth table and checks it against a golden table. Reports pass/fail, error count and the first failing index.
- Replaces hand-written sweep loops in testbenches and lets the same check run on hardware.

Parameters:
- HOLD, 2, cycles each vector is held stable (≥1); Y is sampled on the last of them.
- EXPECTED, 16'h0007, golden truth table; bit i = expected Y for input index i (default = NOR(A,B)·NAND(C,D)).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a scan; ignored while busy
- Y  in  1  output of the block under scan
- A  out  1  stimulus bit 3 (idx[3])
- B  out  1  stimulus bit 2
- C  out  1  stimulus bit 1
- D  out  1  stimulus bit 0
- busy  out  1  high while a scan is in progress
- done  out  1  one-cycle pulse when the scan completes
- pass  out  1  table == EXPECTED; valid from done, held until next accepted start
- table  out  16  captured Y values; bit i = Y at idx i
- err_cnt  out  5  number of mismatching indices (0..16)
- first_err  out  4  lowest mismatching index; 0 when err_cnt == 0

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - State becomes IDLE.
  - A, B, C, D, busy, done and pass are all 0.
  - table is 16'h0000, err_cnt is 0, first_err is 0.
  - rst takes priority over start and over any in-progress scan.
- FSM states: IDLE, SCAN, FINISH.
- IDLE:
  - A..D are held at 0.
  - start=1 at an edge moves the FSM to SCAN and sets idx=0 and hold counter=0.
  - The same edge clears table, err_cnt, first_err and pass.
  - busy goes high in the next cycle.
- SCAN:
  - {A,B,C,D} = idx, registered; driven from the first SCAN cycle.
  - The hold counter counts 0..HOLD-1.
  - At the edge where counter == HOLD-1, the block records table[idx] = Y and compares Y with EXPECTED[idx].
  - On a mismatch, err_cnt increments. If this is the first mismatch, first_err is set to idx.
  - The counter then resets. If idx == 15 the FSM goes to FINISH; otherwise idx increments.
  - Each vector is stable for exactly HOLD cycles.
- FINISH (one cycle):
  - busy is 0, done is 1, pass = (err_cnt == 0).
  - A..D return to 0.
  - Next state is IDLE.
- Timing:
  - With start accepted at edge 0, vector i is driven in cycles i*HOLD+1 .. (i+1)*HOLD.
  - done is high in cycle 16*HOLD+1.
  - Total latency is 16*HOLD+1 cycles.
- start while busy or in FINISH: ignored, no restart.
- start in the cycle immediately after done: accepted normally.
- Results (table, err_cnt, first_err, pass) hold their values in IDLE until the next accepted start.
- Widths:
  - err_cnt is 5 bits, so 16 errors is representable without wrap.
  - idx is 4 bits; the wrap from 15 is never used because the FSM exits to FINISH.
- Y is assumed stable combinationally within HOLD cycles; no synchronizer is included.
- Reset mid-scan: everything returns to reset values, no done pulse is issued, and partial results are discarded.

Decomposition:
- Shared package d02_pkg holds:
  - the state enum (IDLE, SCAN, FINISH);
  - N_IN = 4 and TABLE_W = 16;
  - LAB01_EXPECTED = 16'h0007.
- One natural sub-module, d02_hold_timer:
  - parameter HOLD; inputs clk, rst, clr, en; output last.
  - last is high when the count equals HOLD-1.
  - The top level owns the FSM, idx, capture and compare logic.

Test Plan:
- Correct DUT:
  - Setup: lab01_struct (A..D→Y), HOLD=2, pulse start.
  - Check: done pulses exactly once, in cycle 33.
  - Check: table=16'h0007, err_cnt=0, first_err=0, pass=1.
- Y tied 0:
  - Check: table=0, err_cnt=3, first_err=0, pass=0.
- Y tied 1:
  - Check: table=16'hFFFF, err_cnt=13, first_err=3, pass=0.
- Timing, HOLD=1, correct DUT:
  - Check: {A,B,C,D}==i in cycle i+1 for i=0..15.
  - Check: busy is high in cycles 1..16 and done is high in cycle 17.
- start reapplied at cycle 5 of a scan:
  - Check: no restart; done still arrives in cycle 33 (HOLD=2).
  - Check: a start in cycle 34 begins a fresh scan, and results clear at that edge.
- rst asserted at cycle 10 mid-scan:
  - Check: next cycle busy=0, A..D=0, table=0, err_cnt=0, and no done pulse.
  - Check: a subsequent scan completes with pass=1.
